// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: two-requester round-robin AXI3 write arbiter, one burst owns the master until its B handshake.
// Define AXI_WR_ARB_WLAST_CHECK_EN to generate m_axi_wlast from awlen and flag requester wlast mismatches.
module axi_wr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [ADDR_W-1:0]   s0_awaddr,
    input  logic [3:0]          s0_awlen,
    input  logic                s0_awvalid,
    output logic                s0_awready,
    input  logic [DATA_W-1:0]   s0_wdata,
    input  logic [DATA_W/8-1:0] s0_wstrb,
    input  logic                s0_wlast,
    input  logic                s0_wvalid,
    output logic                s0_wready,
    output logic [1:0]          s0_bresp,
    output logic                s0_bvalid,
    input  logic                s0_bready,
    input  logic [ADDR_W-1:0]   s1_awaddr,
    input  logic [3:0]          s1_awlen,
    input  logic                s1_awvalid,
    output logic                s1_awready,
    input  logic [DATA_W-1:0]   s1_wdata,
    input  logic [DATA_W/8-1:0] s1_wstrb,
    input  logic                s1_wlast,
    input  logic                s1_wvalid,
    output logic                s1_wready,
    output logic [1:0]          s1_bresp,
    output logic                s1_bvalid,
    input  logic                s1_bready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [3:0]          m_axi_awlen,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [1:0]          grant,
    output logic                err_wlast
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    state_t state, state_nxt;
    logic [1:0] grant_nxt;
    logic last_s1, last_s1_nxt;
    logic own1, own_wlast, aw_hs, w_hs, b_hs;
    logic in_addr, in_data, in_resp;

    assign own1 = grant[1];
    assign in_addr = state == ADDR;
    assign in_data = state == DATA;
    assign in_resp = state == RESP;

    // Master side is a pure mux of the owner; everything outside the owning phase reads as zero.
    assign m_axi_awvalid = in_addr && (own1 ? s1_awvalid : s0_awvalid);
    assign m_axi_awaddr  = in_addr ? (own1 ? s1_awaddr : s0_awaddr) : '0;
    assign m_axi_awlen   = in_addr ? (own1 ? s1_awlen : s0_awlen) : 4'd0;
    assign m_axi_wvalid  = in_data && (own1 ? s1_wvalid : s0_wvalid);
    assign m_axi_wdata   = in_data ? (own1 ? s1_wdata : s0_wdata) : '0;
    assign m_axi_wstrb   = in_data ? (own1 ? s1_wstrb : s0_wstrb) : '0;
    assign m_axi_bready  = in_resp && (own1 ? s1_bready : s0_bready);
    assign own_wlast     = own1 ? s1_wlast : s0_wlast;

    assign s0_awready = in_addr && grant[0] && m_axi_awready;
    assign s1_awready = in_addr && grant[1] && m_axi_awready;
    assign s0_wready  = in_data && grant[0] && m_axi_wready;
    assign s1_wready  = in_data && grant[1] && m_axi_wready;
    assign s0_bvalid  = in_resp && grant[0] && m_axi_bvalid;
    assign s1_bvalid  = in_resp && grant[1] && m_axi_bvalid;
    assign s0_bresp   = (in_resp && grant[0]) ? m_axi_bresp : 2'b00;
    assign s1_bresp   = (in_resp && grant[1]) ? m_axi_bresp : 2'b00;

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;
    assign b_hs  = m_axi_bvalid && m_axi_bready;

`ifdef AXI_WR_ARB_WLAST_CHECK_EN
    logic [3:0] beat, awlen_q;
    logic gen_wlast, err_q;
    assign gen_wlast   = beat == awlen_q;
    assign m_axi_wlast = in_data && gen_wlast;
    assign err_wlast   = err_q;
    always_ff @(posedge aclk or posedge areset)
        if (areset) begin
            beat    <= 4'd0;
            awlen_q <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            if (aw_hs) begin
                beat    <= 4'd0;
                awlen_q <= m_axi_awlen;
            end else if (w_hs) begin
                beat <= beat + 4'd1;
            end
            if (w_hs && own_wlast != gen_wlast)
                err_q <= 1'b1;
        end
`else
    assign m_axi_wlast = in_data && own_wlast;
    assign err_wlast   = 1'b0;
`endif

    // Handshakes are only possible in their own phase, so the updates below never collide.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        last_s1_nxt = last_s1;
        if (state == IDLE && (s0_awvalid || s1_awvalid)) begin
            state_nxt = ADDR;
            grant_nxt = (s0_awvalid && s1_awvalid) ? (last_s1 ? 2'b01 : 2'b10) : (s0_awvalid ? 2'b01 : 2'b10);
        end
        if (aw_hs)
            state_nxt = DATA;
        if (w_hs && m_axi_wlast)
            state_nxt = RESP;
        if (b_hs) begin
            state_nxt   = IDLE;
            grant_nxt   = 2'b00;
            last_s1_nxt = grant[1];
        end
    end

    always_ff @(posedge aclk or posedge areset)
        if (areset) begin
            state   <= IDLE;
            grant   <= 2'b00;
            last_s1 <= 1'b1;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            last_s1 <= last_s1_nxt;
        end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb_axi_wr_arbiter: randomized scoreboard bench for axi_wr_arbiter with a transaction-level arbitration model.
// Honors AXI_WR_ARB_WLAST_CHECK_EN when the design is built with it.
module tb_axi_wr_arbiter;
    typedef struct {logic [31:0] addr; logic [3:0] len;} aw_t;
    typedef struct {logic [63:0] data; logic [7:0] strb; logic last;} w_t;

    logic aclk = 1'b0;
    logic areset;
    logic [31:0] s_awaddr[2];
    logic [3:0]  s_awlen[2];
    logic        s_awvalid[2], s_awready[2];
    logic [63:0] s_wdata[2];
    logic [7:0]  s_wstrb[2];
    logic        s_wlast[2], s_wvalid[2], s_wready[2];
    logic [1:0]  s_bresp[2];
    logic        s_bvalid[2], s_bready[2];
    logic [31:0] m_awaddr;
    logic [3:0]  m_awlen;
    logic        m_awvalid, m_awready;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_wlast, m_wvalid, m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid, m_bready;
    logic [1:0]  grant;
    logic        err_wlast;

    int errors = 0, checks = 0;
    aw_t aw0[$], aw1[$];
    w_t  w0[$], w1[$];
    logic [1:0] exp_b[$];
    logic [1:0] exp_grant;
    logic last_s1, err_m;
    bit fast = 0, toggle = 0, bubbles = 1;
    int aw_stall = 0, force_resp = -1;

    axi_wr_arbiter dut (
        .aclk(aclk), .areset(areset),
        .s0_awaddr(s_awaddr[0]), .s0_awlen(s_awlen[0]), .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]),
        .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wlast(s_wlast[0]), .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]),
        .s0_bresp(s_bresp[0]), .s0_bvalid(s_bvalid[0]), .s0_bready(s_bready[0]),
        .s1_awaddr(s_awaddr[1]), .s1_awlen(s_awlen[1]), .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]),
        .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wlast(s_wlast[1]), .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]),
        .s1_bresp(s_bresp[1]), .s1_bvalid(s_bvalid[1]), .s1_bready(s_bready[1]),
        .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
        .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
        .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
        .grant(grant), .err_wlast(err_wlast)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_ready(input int n, input bit is_w, output bit ok);
        int t = 0;
        do begin
            @(negedge aclk);
            t++;
        end while (!(is_w ? s_wready[n] : s_awready[n]) && t < 300);
        ok = is_w ? s_wready[n] : s_awready[n];
        chk(is_w ? "w_ready_wait" : "aw_ready_wait", 64'(ok), 64'(1));
        @(posedge aclk);
        #1;
    endtask

    task automatic send_aw(input int n, input logic [31:0] addr, input logic [3:0] len, output bit ok);
        aw_t a;
        a.addr = addr;
        a.len = len;
        if (n == 0) aw0.push_back(a); else aw1.push_back(a);
        s_awaddr[n] = addr;
        s_awlen[n] = len;
        s_awvalid[n] = 1'b1;
        wait_ready(n, 1'b0, ok);
        s_awvalid[n] = 1'b0;
    endtask

    task automatic send_beat(input int n, input int b, input int len, input int lastb, output bit ok);
        w_t e;
        while (bubbles && $urandom % 4 == 0) begin
            @(posedge aclk);
            #1;
        end
        e.data = {$urandom, $urandom};
        e.strb = 8'($urandom);
`ifdef AXI_WR_ARB_WLAST_CHECK_EN
        e.last = b == len;
`else
        e.last = b == lastb;
`endif
        if (n == 0) w0.push_back(e); else w1.push_back(e);
        s_wdata[n] = e.data;
        s_wstrb[n] = e.strb;
        s_wlast[n] = b == lastb;
        s_wvalid[n] = 1'b1;
        wait_ready(n, 1'b1, ok);
        s_wvalid[n] = 1'b0;
        s_wlast[n] = 1'b0;
    endtask

    task automatic do_burst(input int n, input logic [31:0] addr, input logic [3:0] len, input int lastb);
        bit ok;
        int t = 0;
        send_aw(n, addr, len, ok);
        if (!ok) return;
        for (int b = 0; b <= int'(len); b++) begin
            send_beat(n, b, int'(len), lastb, ok);
            if (!ok) return;
        end
        forever begin
            s_bready[n] = 1'($urandom % 2);
            @(negedge aclk);
            t++;
            if ((s_bvalid[n] && s_bready[n]) || t >= 300) break;
            @(posedge aclk);
            #1;
        end
        chk("b_wait", 64'(s_bvalid[n] && s_bready[n]), 64'(1));
        @(posedge aclk);
        #1;
        s_bready[n] = 1'b0;
    endtask

    // Slave model behind the master port: random or forced ready patterns, one B per last beat.
    initial begin
        bit w_hs, b_hs, aw_seen;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        forever begin
            @(negedge aclk);
            w_hs = m_wvalid && m_wready && m_wlast;
            b_hs = m_bvalid && m_bready;
            aw_seen = m_awvalid;
            @(posedge aclk);
            #1;
            if (areset) begin
                m_bvalid = 0; m_awready = 0; m_wready = 0;
            end else begin
                if (b_hs) m_bvalid = 0;
                if (w_hs) begin
                    m_bvalid = 1;
                    m_bresp = force_resp >= 0 ? 2'(force_resp) : 2'($urandom);
                    exp_b.push_back(m_bresp);
                end
                if (aw_stall > 0) begin
                    m_awready = 0;
                    if (aw_seen) aw_stall--;
                end else begin
                    m_awready = fast || ($urandom % 3 != 0);
                end
                m_wready = toggle ? ~m_wready : (fast || ($urandom % 4 != 0));
            end
        end
    end

    // Monitor: compares every observed handshake against the queues and the arbitration model.
    initial begin
        aw_t ma;
        w_t me;
        int idx, np;
        logic bad;
        forever begin
            @(negedge aclk);
            if (areset) begin
                aw0.delete(); aw1.delete(); w0.delete(); w1.delete(); exp_b.delete();
                exp_grant = 2'b00; last_s1 = 1'b1; err_m = 1'b0;
                chk("reset_ctrl", 64'({grant, err_wlast, m_awvalid, m_wvalid, m_bready, s_awready[0], s_awready[1],
                    s_wready[0], s_wready[1], s_bvalid[0], s_bvalid[1]}), 64'(0));
                chk("reset_data", 64'(m_awaddr) | m_wdata | 64'(m_wstrb) | 64'(m_awlen) | 64'(m_wlast), 64'(0));
            end else begin
                chk("grant", 64'(grant), 64'(exp_grant));
                chk("err_wlast", 64'(err_wlast), 64'(err_m));
                bad = 1'b0;
                for (int i = 0; i < 2; i++)
                    if (!exp_grant[i]) bad |= s_awready[i] | s_wready[i] | s_bvalid[i];
                if (exp_grant == 2'b00) bad |= m_awvalid | m_wvalid | m_bready;
                chk("non_owner_quiet", 64'(bad), 64'(0));
                idx = grant[1] ? 1 : 0;
                if (m_awvalid && m_awready) begin
                    np = idx ? aw1.size() : aw0.size();
                    chk("aw_expected", 64'(np > 0), 64'(1));
                    if (np > 0) begin
                        if (idx) ma = aw1.pop_front(); else ma = aw0.pop_front();
                        chk("awaddr", 64'(m_awaddr), 64'(ma.addr));
                        chk("awlen", 64'(m_awlen), 64'(ma.len));
                        chk("aw_owner_ready", 64'(s_awready[idx]), 64'(1));
                    end
                end
                if (m_wvalid && m_wready) begin
                    np = idx ? w1.size() : w0.size();
                    chk("w_expected", 64'(np > 0), 64'(1));
                    if (np > 0) begin
                        if (idx) me = w1.pop_front(); else me = w0.pop_front();
                        chk("wdata", m_wdata, me.data);
                        chk("wstrb", 64'(m_wstrb), 64'(me.strb));
                        chk("wlast", 64'(m_wlast), 64'(me.last));
                        if (s_wlast[idx] != me.last) err_m = 1'b1;
                    end
                end
                for (int i = 0; i < 2; i++)
                    if (s_bvalid[i] && s_bready[i]) begin
                        chk("b_owner", 64'(i), 64'(exp_grant[1] ? 1 : 0));
                        chk("b_expected", 64'(exp_b.size() > 0), 64'(1));
                        if (exp_b.size() > 0) chk("bresp", 64'(s_bresp[i]), 64'(exp_b.pop_front()));
                    end
                if (exp_grant == 2'b00) begin
                    if (s_awvalid[0] && s_awvalid[1]) exp_grant = last_s1 ? 2'b01 : 2'b10;
                    else if (s_awvalid[0]) exp_grant = 2'b01;
                    else if (s_awvalid[1]) exp_grant = 2'b10;
                end else if (m_bvalid && m_bready) begin
                    last_s1 = exp_grant[1];
                    exp_grant = 2'b00;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0] l0, l1;
        bit ok;
        areset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_awaddr[i] = 0; s_awlen[i] = 0; s_awvalid[i] = 0; s_wdata[i] = 0; s_wstrb[i] = 0;
            s_wlast[i] = 0; s_wvalid[i] = 0; s_bready[i] = 0;
        end
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        // simultaneous requests: s0 first after reset, then alternation
        for (int k = 0; k < 3; k++)
            fork
                do_burst(0, 32'h100 + 32'(k), 4'd1, 1);
                do_burst(1, 32'h200 + 32'(k), 4'd2, 2);
            join
        // single 16-beat burst with an always-ready slave
        fast = 1; bubbles = 0;
        do_burst(0, 32'h1000, 4'd15, 15);
        // address stall and toggling wready while the other requester waits
        fast = 0; toggle = 1; aw_stall = 5;
        repeat (2) @(posedge aclk);
        #1;
        fork
            do_burst(0, 32'h2000, 4'd7, 7);
            begin
                @(posedge aclk);
                #1;
                do_burst(1, 32'h3000, 4'd4, 4);
            end
        join
        toggle = 0;
        // SLVERR routed to s1
        force_resp = 2;
        do_burst(1, 32'h4000, 4'd3, 3);
        force_resp = -1;
        bubbles = 1;
        fork
            for (int k = 0; k < 15; k++) begin
                repeat ($urandom % 4) @(posedge aclk);
                #1;
                l0 = 4'($urandom);
                do_burst(0, $urandom, l0, int'(l0));
            end
            for (int k = 0; k < 15; k++) begin
                repeat ($urandom % 4) @(posedge aclk);
                #1;
                l1 = 4'($urandom);
                do_burst(1, $urandom, l1, int'(l1));
            end
        join
        // reset while the fifth data beat of an s0 burst is presented
        fast = 1; bubbles = 0;
        repeat (3) @(posedge aclk);
        #1;
        send_aw(0, 32'h5000, 4'd7, ok);
        for (int b = 0; b < 4; b++) send_beat(0, b, 7, 7, ok);
        s_wdata[0] = 64'hdead_beef_0000_0005;
        s_wstrb[0] = 8'hff;
        s_wvalid[0] = 1'b1;
        #1 chk("beat5_presented", 64'(m_wvalid), 64'(1));
        #1 areset = 1'b1;
        #1 chk("reset_mid_burst", 64'({grant, m_awvalid, m_wvalid, m_bready, s_awready[0], s_awready[1], s_wready[0],
            s_wready[1], s_bvalid[0], s_bvalid[1]}) | m_wdata, 64'(0));
        s_wvalid[0] = 1'b0;
        @(posedge aclk);
        #3 areset = 1'b0;
        @(posedge aclk);
        #1;
        do_burst(1, 32'h6000, 4'd2, 2);
`ifdef AXI_WR_ARB_WLAST_CHECK_EN
        do_burst(0, 32'h7000, 4'd3, 1);
        @(negedge aclk);
        chk("err_wlast_set", 64'(err_wlast), 64'(1));
        @(posedge aclk);
        #1 areset = 1'b1;
        #1 chk("err_wlast_cleared", 64'(err_wlast), 64'(0));
        @(posedge aclk);
        #3 areset = 1'b0;
`endif
        repeat (5) @(posedge aclk);
        #1;
        chk("queues_drained", 64'(aw0.size() + aw1.size() + w0.size() + w1.size() + exp_b.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
